// File: rtl/fuzz_mix_pkg.sv
// Shared constants for the fuzz_mix pipeline: result width extension and signature LFSR parameters.
package fuzz_mix_pkg;

  localparam int          Y_EXTRA   = 3;
  localparam logic [31:0] SIG_RESET = 32'hFFFF_FFFF;
  // Feedback taps at bits 31, 21, 1 and 0.
  localparam logic [31:0] SIG_TAPS  = 32'h8020_0003;

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], ^(s & SIG_TAPS)} ^ d;
  endfunction

endpackage

// File: rtl/fuzz_mix_core.sv
// Combinational evaluation of t5..t8 and packing into y = {t6, t7, t8}.
module fuzz_mix_core
  import fuzz_mix_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0]         in0_i,
  input  logic [W-1:0]         in1_i,
  input  logic signed [W-1:0]  in2_i,
  input  logic [W-1:0]         in3_i,
  input  logic signed [W-1:0]  in4_i,
  output logic [W+Y_EXTRA-1:0] y_o
);

  logic [W-1:0] t5_s;
  logic [W-1:0] sel_s;
  logic [W-1:0] t6_s;
  logic [1:0]   t7_s;
  logic         t8_s;

  // Operand mixing; signedness of in2/in4 only matters for zero tests, which it does not affect.
  always_comb begin
    t5_s  = in3_i >> 3'd3;
    sel_s = $unsigned(in4_i) | (in1_i ^ in0_i);
    if (sel_s == {W{1'b0}}) begin
      t6_s = ~(t5_s ^ in1_i);
    end else begin
      t6_s = in1_i >> 2'd2;
    end
    if (in2_i != {W{1'b0}}) begin
      t7_s = {1'b0, t5_s[3]};
    end else begin
      t7_s = t5_s[3:2];
    end
    t8_s = (t5_s == {W{1'b0}});
  end

  assign y_o = {t6_s, t7_s, t8_s};

endmodule

// File: rtl/fuzz_mix_pipe.sv
// Valid/ready pipeline around fuzz_mix_core with handshake counter.
// Optional running signature enabled by macro FUZZ_MIX_SIG_EN.
module fuzz_mix_pipe
  import fuzz_mix_pkg::*;
#(
  parameter int W     = 11,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in0,
  input  logic [W-1:0]         in1,
  input  logic signed [W-1:0]  in2,
  input  logic [W-1:0]         in3,
  input  logic signed [W-1:0]  in4,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+Y_EXTRA-1:0] y,
  output logic [CNT_W-1:0]     count,
  output logic [31:0]          sig
);

  localparam int YW = W + Y_EXTRA;

  logic [YW-1:0]    core_y_s;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [YW-1:0]    dat_q [DEPTH];
  logic [YW-1:0]    dat_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_s;
  logic             out_hs_s;

  fuzz_mix_core #(.W(W)) u_core (
    .in0_i (in0),
    .in1_i (in1),
    .in2_i (in2),
    .in3_i (in3),
    .in4_i (in4),
    .y_o   (core_y_s)
  );

  assign stall_s   = vld_q[DEPTH-1] & ~out_ready;
  assign out_hs_s  = vld_q[DEPTH-1] & out_ready;
  assign in_ready  = ~rst & ~stall_s;
  assign out_valid = vld_q[DEPTH-1];
  assign y         = dat_q[DEPTH-1];
  assign count     = count_q;

  // Stage advance: whole pipeline shifts unless the output is stalled.
  always_comb begin
    vld_d   = vld_q;
    dat_d   = dat_q;
    count_d = count_q;
    if (!stall_s) begin
      vld_d[0] = in_valid;
      dat_d[0] = core_y_s;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end else begin
      vld_d = vld_q;
      dat_d = dat_q;
    end
    if (out_hs_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= {DEPTH{1'b0}};
      count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= {YW{1'b0}};
      end
    end else begin
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      count_q <= count_d;
    end
  end

`ifdef FUZZ_MIX_SIG_EN
  logic [63:0] y_ext_s;
  logic [31:0] sig_q, sig_d;

  assign y_ext_s = 64'(dat_q[DEPTH-1]);
  assign sig     = sig_q;

  // Signature advances once per output handshake.
  always_comb begin
    sig_d = sig_q;
    if (out_hs_s) begin
      sig_d = sig_step(sig_q, y_ext_s[31:0]);
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SIG_RESET;
    end else begin
      sig_q <= sig_d;
    end
  end
`else
  assign sig = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fuzz_mix_pipe.sv
// Directed table-driven bench for fuzz_mix_pipe (W=11, DEPTH=2, CNT_W=4).
module tb_fuzz_mix_pipe;

  localparam int W     = 11;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int YW    = W + 3;
`ifdef FUZZ_MIX_SIG_EN
  localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] SIG_809  = 32'hFFFF_F7F7;
`else
  localparam logic [31:0] SIG_INIT = 32'h0000_0000;
  localparam logic [31:0] SIG_809  = 32'h0000_0000;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in0, in1, in3;
  logic signed [W-1:0] in2, in4;
  logic                out_valid;
  logic                out_ready;
  logic [YW-1:0]       y;
  logic [CNT_W-1:0]    count;
  logic [31:0]         sig;

  always #5 clk = ~clk;

  fuzz_mix_pipe #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .count     (count),
    .sig       (sig)
  );

  typedef struct {
    logic [W-1:0]  a0, a1, a2, a3, a4;
    logic [YW-1:0] ey;
  } vec_t;

  vec_t          tbl [9];
  logic [YW-1:0] exp_q [$];
  logic [YW-1:0] cur_exp;
  logic [CNT_W-1:0] exp_cnt;
  logic [31:0]   exp_sig;
  logic          last_acc;
  int            n_pass  = 0;
  int            n_total = 0;

  function automatic logic [31:0] sig_model(input logic [31:0] s, input logic [YW-1:0] d);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ {{(32-YW){1'b0}}, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input int i);
    in0 = tbl[i].a0; in1 = tbl[i].a1; in2 = tbl[i].a2;
    in3 = tbl[i].a3; in4 = tbl[i].a4; cur_exp = tbl[i].ey;
  endtask

  // One clock: observe handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [YW-1:0] e;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("y_stream", 64'(y), 64'(e));
        exp_cnt++;
`ifdef FUZZ_MIX_SIG_EN
        exp_sig = sig_model(exp_sig, e);
`endif
      end
    end
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nacc;
    bit have;
    logic [YW-1:0] held;

    tbl[0] = '{11'h000, 11'h000, 11'h000, 11'h1F8, 11'h000, 14'h3E06};
    tbl[1] = '{11'h000, 11'h404, 11'h005, 11'h000, 11'h000, 14'h0809};
    tbl[2] = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 14'h3FF9};
    tbl[3] = '{11'h123, 11'h123, 11'h000, 11'h7FF, 11'h000, 14'h311E};
    tbl[4] = '{11'h123, 11'h123, 11'h7FF, 11'h7FF, 11'h000, 14'h311A};
    tbl[5] = '{11'h000, 11'h7FF, 11'h001, 11'h010, 11'h400, 14'h0FF8};
    tbl[6] = '{11'h005, 11'h005, 11'h000, 11'h00C, 11'h000, 14'h3FD8};
    tbl[7] = '{11'h001, 11'h000, 11'h000, 11'h028, 11'h000, 14'h0002};
    tbl[8] = '{11'h001, 11'h000, 11'h003, 11'h028, 11'h000, 14'h0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0; in4 = '0; cur_exp = '0;
    exp_cnt = '0; exp_sig = SIG_INIT; last_acc = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_sig", 64'(sig), 64'(SIG_INIT));
    chk("rst_in_ready_after", 64'(in_ready), 64'd1);

    // Latency of a single result.
    drive(0); in_valid = 1'b1; tick(); in_valid = 1'b0;
    chk("lat_1cyc", 64'(out_valid), 64'd0);
    tick();
    chk("lat_2cyc", 64'(out_valid), 64'd1);
    chk("lat_y", 64'(y), 64'h3E06);
    tick();
    chk("lat_count", 64'(count), 64'd1);
    chk("lat_sig", 64'(sig), 64'(exp_sig));

    // Full-throughput table stream.
    for (int i = 0; i < 9; i++) begin
      drive(i); in_valid = 1'b1; tick();
      chk("thru_accept", 64'(last_acc), 64'd1);
    end
    drain();
    chk("stream_count", 64'(count), 64'(exp_cnt));
    chk("stream_sig", 64'(sig), 64'(exp_sig));

    // Back-pressure: out_ready low for 5 cycles while offering 4 operand sets.
    out_ready = 1'b0; nacc = 0; have = 1'b0; held = '0;
    for (int c = 0; c < 5; c++) begin
      if (nacc < 4) begin drive(3 + nacc); in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick();
      if (last_acc) nacc++;
      if (out_valid) begin
        if (!have) begin held = y; have = 1'b1; end
        else begin
          chk("stall_y_hold", 64'(y), 64'(held));
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
      end
    end
    chk("stall_accepted", 64'(nacc), 64'd2);
    chk("stall_head", 64'(held), 64'h311E);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && (nacc < 4 || exp_q.size() != 0); n++) begin
      if (nacc < 4) begin drive(3 + nacc); in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick();
      if (last_acc) nacc++;
    end
    in_valid = 1'b0;
    chk("stall_all_accepted", 64'(nacc), 64'd4);
    chk("stall_none_lost", 64'(exp_q.size()), 64'd0);
    chk("stall_count", 64'(count), 64'(exp_cnt));

    // Reset with two results in flight.
    drive(4); in_valid = 1'b1; tick();
    drive(5); tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    exp_q.delete(); exp_cnt = '0; exp_sig = SIG_INIT;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_sig", 64'(sig), 64'(SIG_INIT));
    chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("no_stale", 64'(out_valid), 64'd0);
    end

    // Single 0x809 result from reset fixes the signature; then wrap the 4-bit counter.
    drive(1); in_valid = 1'b1; tick();
    drain();
    chk("first_count", 64'(count), 64'd1);
    chk("sig_after_809", 64'(sig), 64'(SIG_809));
    for (int i = 0; i < 16; i++) begin
      drive(i % 9); in_valid = 1'b1; tick();
    end
    drain();
    chk("wrap_count", 64'(count), 64'd1);
    chk("wrap_count_model", 64'(count), 64'(exp_cnt));
    chk("wrap_sig", 64'(sig), 64'(exp_sig));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
